// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder cell, one operand bit per clock, LSB first.
// Latency: WIDTH+1 cycles from the accepted start to the done pulse; one operation every WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE and requests seen while busy are dropped, not queued.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  // Full-adder cell on the current LSBs of the operand shift registers.
  logic bit_s;
  logic bit_c;
  logic last_bit;

  assign bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign bit_c    = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);
  assign last_bit = (cnt_q == LAST_BIT);

  // State register plus all datapath registers; reset clears everything and wins over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: accept start in IDLE, run WIDTH bits, spend one cycle in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-values: load on accept, one bit per SHIFT cycle, publish results on the last bit.
  always_comb begin
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
          a_sr_d  = A;
          b_sr_d  = sub ? ~B : B;
          carry_d = sub;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
        s_sr_d  = {bit_s, s_sr_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_bit) begin
          // On the MSB the incoming carry_q is the carry into the MSB, so overflow
          // is taken directly from it instead of keeping a separate copy.
          sum_d  = {bit_s, s_sr_q[WIDTH-1:1]};
          cout_d = bit_c;
          ovf_d  = carry_q ^ bit_c;
        end
      end
      default: ;
    endcase
  end

  // Status outputs are pure decodes of the state register.
  always_comb begin
    busy = (state_q == S_SHIFT);
    done = (state_q == S_DONE);
  end

  assign Sum  = sum_q;
  assign Cout = cout_q;
  assign Ovf  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_r   [3];
  logic        start_r [3];
  logic        sub_r   [3];
  logic [15:0] a_r     [3];
  logic [15:0] b_r     [3];
  logic        busy_w  [3];
  logic        done_w  [3];
  logic        cout_w  [3];
  logic        ovf_w   [3];
  logic [2:0]  sum3;
  logic [7:0]  sum8;
  logic [15:0] sum16;

  logic [17:0] held [3];   // {Cout, Ovf, Sum} the bench expects to see held
  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst(rst_r[0]), .start(start_r[0]), .sub(sub_r[0]),
    .A(a_r[0][2:0]), .B(b_r[0][2:0]), .busy(busy_w[0]), .done(done_w[0]),
    .Sum(sum3), .Cout(cout_w[0]), .Ovf(ovf_w[0]));

  serial_addsub #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst_r[1]), .start(start_r[1]), .sub(sub_r[1]),
    .A(a_r[1][7:0]), .B(b_r[1][7:0]), .busy(busy_w[1]), .done(done_w[1]),
    .Sum(sum8), .Cout(cout_w[1]), .Ovf(ovf_w[1]));

  serial_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst_r[2]), .start(start_r[2]), .sub(sub_r[2]),
    .A(a_r[2]), .B(b_r[2]), .busy(busy_w[2]), .done(done_w[2]),
    .Sum(sum16), .Cout(cout_w[2]), .Ovf(ovf_w[2]));

  function automatic int w_of(input int k);
    return (k == 0) ? 3 : (k == 1) ? 8 : 16;
  endfunction

  function automatic logic [17:0] get_res(input int k);
    logic [15:0] s;
    s = (k == 0) ? {13'd0, sum3} : (k == 1) ? {8'd0, sum8} : sum16;
    return {cout_w[k], ovf_w[k], s};
  endfunction

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the mathematical values of the operands.
  task automatic model(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                       output logic [17:0] res);
    longint m, half, ua, ub, sa, sb, r, rs;
    logic c, o;
    m    = longint'(1) << w;
    half = m >> 1;
    ua   = longint'(a) & (m - 1);
    ub   = longint'(b) & (m - 1);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (s) begin
      r  = ua - ub;
      c  = (ua >= ub);
      rs = sa - sb;
    end else begin
      r  = ua + ub;
      c  = (r >= m);
      rs = sa + sb;
    end
    o   = (rs >= half) || (rs < -half);
    res = {c, o, 16'(r & (m - 1))};
  endtask

  // One operation on instance k: checks latency, busy, held outputs during SHIFT and the result.
  task automatic run_op(input int k, input logic s, input logic [15:0] a, input logic [15:0] b);
    logic [17:0] exp;
    int lat;
    model(w_of(k), s, a, b, exp);
    @(negedge clk);
    start_r[k] = 1'b1; sub_r[k] = s; a_r[k] = a; b_r[k] = b;
    @(negedge clk);
    start_r[k] = 1'b0; sub_r[k] = ~s;
    a_r[k] = 16'($urandom); b_r[k] = 16'($urandom);
    lat = 1;
    check_val("busy_after_start", 64'(busy_w[k]), 64'd1);
    while (!done_w[k] && lat < 40) begin
      if (busy_w[k]) check_val("hold_while_busy", 64'(get_res(k)), 64'(held[k]));
      @(negedge clk);
      lat++;
    end
    check_val("latency", 64'(lat), 64'(w_of(k) + 1));
    check_val("busy_at_done", 64'(busy_w[k]), 64'd0);
    check_val("result", 64'(get_res(k)), 64'(exp));
    held[k] = exp;
    @(negedge clk);
    check_val("done_one_cycle", 64'(done_w[k]), 64'd0);
  endtask

  initial begin
    int dn, t0, last_t;
    int t [4];
    for (int k = 0; k < 3; k++) begin
      rst_r[k] = 1'b1; start_r[k] = 1'b0; sub_r[k] = 1'b0;
      a_r[k] = '0; b_r[k] = '0; held[k] = '0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) rst_r[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_val("reset_busy", 64'(busy_w[k]), 64'd0);
      check_val("reset_done", 64'(done_w[k]), 64'd0);
      check_val("reset_result", 64'(get_res(k)), 64'd0);
    end

    // Directed WIDTH=3 and WIDTH=8 cases.
    run_op(0, 1'b0, 16'b011, 16'b101);
    run_op(0, 1'b0, 16'b111, 16'b111);
    run_op(0, 1'b0, 16'b001, 16'b001);
    run_op(0, 1'b1, 16'b010, 16'b100);
    run_op(0, 1'b1, 16'b101, 16'b001);
    run_op(1, 1'b0, 16'h7F, 16'h01);
    run_op(1, 1'b1, 16'h80, 16'h01);
    run_op(1, 1'b0, 16'hFF, 16'h01);

    // Second start while busy is dropped; operand changes after the start edge are harmless.
    @(negedge clk);
    start_r[1] = 1'b1; sub_r[1] = 1'b0; a_r[1] = 16'h10; b_r[1] = 16'h20;
    dn = 0; t0 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) begin start_r[1] = 1'b0; sub_r[1] = 1'b1; a_r[1] = 16'hFF; b_r[1] = 16'hFF; end
      if (c == 3) begin start_r[1] = 1'b1; a_r[1] = 16'h55; b_r[1] = 16'h11; end
      if (c == 4) start_r[1] = 1'b0;
      if (done_w[1]) begin dn++; if (t0 < 0) t0 = c; end
    end
    check_val("hs_done_count", 64'(dn), 64'd1);
    check_val("hs_latency", 64'(t0), 64'd9);
    check_val("hs_result", 64'(get_res(1)), {46'd0, 2'b00, 16'h0030});
    held[1] = {2'b00, 16'h0030};

    // start held high: one accepted operation every WIDTH+2 cycles.
    @(negedge clk);
    start_r[1] = 1'b1; sub_r[1] = 1'b0; a_r[1] = 16'h01; b_r[1] = 16'h02;
    dn = 0; last_t = 0;
    for (int c = 1; c <= 60 && dn < 4; c++) begin
      @(negedge clk);
      if (done_w[1]) begin
        t[dn] = c; dn++;
        if (dn == 4) start_r[1] = 1'b0;
      end
      last_t = c;
    end
    check_val("b2b_done_count", 64'(dn), 64'd4);
    if (dn == 4) begin
      check_val("b2b_first", 64'(t[0]), 64'd9);
      for (int i = 1; i < 4; i++) check_val("b2b_interval", 64'(t[i] - t[i-1]), 64'd10);
    end
    check_val("b2b_result", 64'(get_res(1)), {46'd0, 2'b00, 16'h0003});
    held[1] = {2'b00, 16'h0003};
    @(negedge clk);

    // Reset while bit 4 of 0xAA+0x55 is being processed.
    @(negedge clk);
    start_r[1] = 1'b1; sub_r[1] = 1'b0; a_r[1] = 16'hAA; b_r[1] = 16'h55;
    @(negedge clk);
    start_r[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_busy_before", 64'(busy_w[1]), 64'd1);
    rst_r[1] = 1'b1;
    @(negedge clk);
    rst_r[1] = 1'b0;
    check_val("rst_busy", 64'(busy_w[1]), 64'd0);
    check_val("rst_result", 64'(get_res(1)), 64'd0);
    held[1] = '0;
    dn = 0;
    for (int c = 0; c < 15; c++) begin
      if (done_w[1]) dn++;
      @(negedge clk);
    end
    check_val("rst_no_done", 64'(dn), 64'd0);
    run_op(1, 1'b0, 16'h01, 16'h01);

    // Exhaustive WIDTH=3, both modes.
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 8; a++)
        for (int b = 0; b < 8; b++)
          run_op(0, 1'(s), 16'(a), 16'(b));

    // Random WIDTH=16, both modes.
    for (int i = 0; i < 1000; i++)
      run_op(2, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor: one full-adder cell and a carry flip-flop process one operand bit per clock, LSB first. Operands are loaded in parallel on a start handshake. The result, carry-out and signed-overflow flag are presented in parallel after WIDTH clocks. It generalises the team's fixed 3-bit serial adder with these additions:
- arbitrary width
- subtract mode
- a busy/done handshake
- registered, held results

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- sub  in  1  0 = A+B, 1 = A−B; sampled with start
- A  in  WIDTH  operand A; sampled with start
- B  in  WIDTH  operand B; sampled with start
- busy  out  1  high while bits are being processed (SHIFT state)
- done  out  1  one-cycle pulse: result registers just updated
- Sum  out  WIDTH  result, held until next completion
- Cout  out  1  carry out of MSB; in subtract mode 1 = no borrow (A ≥ B unsigned)
- Ovf  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- States:
  - IDLE: start=1 loads the operand shift registers: a_sr←A, b_sr←(sub ? ~B : B). It also sets carry←sub, cnt←0, and goes to SHIFT.
  - SHIFT: each cycle, s = a_sr[0]^b_sr[0]^carry.
    - carry ← majority(a_sr[0], b_sr[0], carry).
    - a_sr and b_sr shift right by one.
    - s_sr ← {s, s_sr[WIDTH-1:1]}.
    - cnt increments.
    - When processing bit WIDTH−1, the incoming carry is also stored as c_msb.
    - After the bit with cnt = WIDTH−1, go to DONE.
  - DONE:
    - Sum←s_sr, Cout←carry, Ovf←c_msb^carry were written on the entry edge.
    - done=1 for this one cycle; next state is IDLE unconditionally.
- start is ignored in SHIFT and DONE. A request raised then must be re-asserted, or held, until IDLE. No queuing.
- A, B and sub may change freely after the start edge; internal copies are used.
- Sum, Cout and Ovf change only on the DONE-entry edge or on reset. They are never partially updated during SHIFT.
- Arithmetic is modulo 2^WIDTH. Cout is the true carry from the full WIDTH-bit addition of A + (sub ? ~B+1 : B).
- cnt width is $clog2(WIDTH).
- rst=1 on any edge, in any state including mid-SHIFT:
  - state←IDLE; busy=0, done=0, Sum=0, Cout=0, Ovf=0.
  - Shift registers, carry and cnt are cleared.
  - The aborted operation produces no done.
  - rst wins over a simultaneous start.

## Timing
- Edge E0 samples start=1 in IDLE. busy=1 from after E0 through after E(WIDTH−1); bits 0..WIDTH−1 are processed at edges E1..EWIDTH.
- EWIDTH writes the results: busy=0, done=1 during the cycle after EWIDTH, and Sum/Cout/Ovf are valid from that cycle onward.
- EWIDTH+1 returns to IDLE (done=0). The earliest next accepted start is at EWIDTH+2.
- Latency from start to done is WIDTH+1 cycles. Throughput is one operation per WIDTH+2 cycles.
- Outputs are all registered; there is no combinational path from inputs to outputs.
- Reset values: busy=0, done=0, Sum=0, Cout=0, Ovf=0, state IDLE.

## Test plan
- WIDTH=3, add:
  - A=3'b011, B=3'b101 -> Sum=3'b000, Cout=1, Ovf=0.
  - A=3'b111, B=3'b111 -> Sum=3'b110, Cout=1, Ovf=0.
  - A=3'b001, B=3'b001 -> Sum=3'b010, Cout=0.
  - In each case done pulses exactly 4 cycles after the start edge.
- WIDTH=3, subtract:
  - A=3'b010, B=3'b100 -> Sum=3'b110, Cout=0 (borrow), Ovf=1 (2−(−4)=6 overflows).
  - A=3'b101, B=3'b001 -> Sum=3'b100, Cout=1, Ovf=0.
- WIDTH=8, signed overflow:
  - 0x7F+0x01 -> Sum=0x80, Cout=0, Ovf=1.
  - 0x80−0x01 -> Sum=0x7F, Cout=1, Ovf=1.
  - 0xFF+0x01 -> Sum=0x00, Cout=1, Ovf=0.
- Handshake (WIDTH=8):
  - Pulse start with 0x10+0x20, then pulse start again with different operands 3 cycles later.
  - Required: the second request is ignored; Sum=0x30 with exactly one done.
  - Operands changed after the start edge do not affect the result.
  - Back-to-back: start held high continuously -> operations are accepted every 10 cycles.
- Reset mid-operation (WIDTH=8):
  - Assert rst for 1 cycle at bit 4 of 0xAA+0x55.
  - Required: busy=0, Sum=0, Cout=0, Ovf=0 after that edge, and no done pulse.
  - A following start with 0x01+0x01 gives Sum=0x02 with normal latency.
- Randomised sweep, WIDTH=3 exhaustive and WIDTH=16 with 1000 vectors, both modes: Sum, Cout and Ovf match the behavioural model, and Sum/Cout/Ovf stay stable while busy.
